// File: rtl/i2s_mstr_tx.sv
// i2s_mstr_tx: Philips I2S master transmitter, 24-bit L/R pairs in 32-bit slots.
// Latency: a pair accepted before a frame load starts shifting out one sclk after that load.
// Backpressure: rdy is low while the single holding buffer is full, and rises the clk after the frame load.
//
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   lft_smpl, rght_smpl  sample pair, captured on vld && rdy
//   vld / rdy            sample pair handshake (rdy = holding buffer empty)
//   I2S_sclk, I2S_ws     generated bit clock and word select (0 = left)
//   I2S_data             serial data, MSB first, changes on the falling sclk edge
//   frm_strt             one-clk pulse when a frame is loaded into the shadow
//   undrrun              one-clk pulse when that load found the holding buffer empty
//
// Build option: define UNDERRUN_HOLD_EN to repeat the previous pair on underrun
// instead of sending zeros.
module i2s_mstr_tx #(
  parameter int SCLK_DIV = 16,
  parameter int SMPL_W   = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SMPL_W-1:0] lft_smpl,
  input  logic [SMPL_W-1:0] rght_smpl,
  input  logic              vld,
  output logic              rdy,
  output logic              I2S_sclk,
  output logic              I2S_ws,
  output logic              I2S_data,
  output logic              frm_strt,
  output logic              undrrun
);

  localparam int               DIV_W    = $clog2(SCLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
  // Unused low bits of each 32-bit slot.
  localparam int               PAD      = 32 - SMPL_W;

  logic [DIV_W-1:0]  div_cnt;
  logic [5:0]        f;
  logic              hold_full;
  logic [SMPL_W-1:0] hold_l;
  logic [SMPL_W-1:0] hold_r;
  logic [SMPL_W-1:0] shd_l;
  logic [SMPL_W-1:0] shd_r;

  logic              tick;
  logic              fall;
  logic              load;
  logic [5:0]        f_nxt;
  logic              ws_nxt;
  logic [63:0]       slot_bits;
  logic              data_nxt;

  assign rdy = ~hold_full;

  always_comb begin
    tick      = (div_cnt == DIV_LAST);
    fall      = tick && I2S_sclk;
    f_nxt     = f + 6'd1;
    load      = fall && (f == 6'd62);
    // ws leads the MSB by one bit: it flips at the last bit of the previous slot.
    ws_nxt    = (f_nxt >= 6'd31) && (f_nxt <= 6'd62);
    // Whole frame laid out MSB-first from bit 63: left slot, then right slot,
    // each sample left-justified with zero padding below it.
    slot_bits = {32'(shd_l) << PAD, 32'(shd_r) << PAD};
    // Bit position 63-f of the frame is simply ~f for a 6-bit index.
    data_nxt  = slot_bits[~f_nxt];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt   <= '0;
      f         <= 6'd62;
      I2S_sclk  <= 1'b0;
      I2S_ws    <= 1'b1;
      I2S_data  <= 1'b0;
      frm_strt  <= 1'b0;
      undrrun   <= 1'b0;
      hold_full <= 1'b0;
      hold_l    <= '0;
      hold_r    <= '0;
      shd_l     <= '0;
      shd_r     <= '0;
    end else begin
      frm_strt <= 1'b0;
      undrrun  <= 1'b0;

      if (tick) begin
        div_cnt  <= '0;
        I2S_sclk <= ~I2S_sclk;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      if (fall) begin
        f        <= f_nxt;
        I2S_ws   <= ws_nxt;
        I2S_data <= data_nxt;
      end

      // The load samples hold_full before any same-clk capture, so a pair
      // arriving on the load clk waits for the following frame.
      if (load) begin
        frm_strt <= 1'b1;
        undrrun  <= ~hold_full;
        if (hold_full) begin
          shd_l <= hold_l;
          shd_r <= hold_r;
        end else begin
`ifdef UNDERRUN_HOLD_EN
          shd_l <= shd_l;
          shd_r <= shd_r;
`else
          shd_l <= '0;
          shd_r <= '0;
`endif
        end
      end

      // Capture only when empty; a load only clears a full buffer, so the
      // two branches never compete for the same clk.
      if (vld && !hold_full) begin
        hold_l    <= lft_smpl;
        hold_r    <= rght_smpl;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end
    end
  end

endmodule
